// File: rtl/dp_pkg.sv
// Shared encodings and FSM state type for the dp_core datapath.
// Optional multiplier is enabled by defining DP_MUL_EN.
package dp_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_MVN = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic WSEL_ALU = 1'b0;
    localparam logic WSEL_MEM = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_MUL,
        S_WB
    } state_t;

    // Without the multiplier, op 110 degrades to a NOP.
    function automatic logic op_is_nop(input logic [2:0] op);
`ifdef DP_MUL_EN
        return (op == OP_NOP);
`else
        return (op == OP_NOP) || (op == OP_MUL);
`endif
    endfunction

    function automatic logic op_writes(input logic [2:0] op);
        return !(op_is_nop(op) || (op == OP_CMP));
    endfunction

endpackage

// File: rtl/dp_regfile.sv
// NREG x W register file: synchronous write, two asynchronous read ports,
// cleared asynchronously on rst_n.
module dp_regfile
    import dp_pkg::*;
#(
    parameter  int W    = 16,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dp_core.sv
// Self-sequencing multi-cycle datapath: IDLE -> READ -> EXEC -> WB, with an
// optional iterative MUL state built only when DP_MUL_EN is defined.
module dp_core
    import dp_pkg::*;
#(
    parameter  int W    = 16,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [W-1:0]  imm,
    input  logic          use_imm,
    input  logic [1:0]    shift,
    input  logic          wsel,
    input  logic [W-1:0]  mdata,
    output logic          resp_valid,
    output logic [W-1:0]  result,
    output logic          z_out,
    output logic          n_out,
    output logic          v_out
);

    state_t        state_reg;
    logic [2:0]    op_reg;
    logic [AW-1:0] rd_reg, rs1_reg, rs2_reg;
    logic [W-1:0]  imm_reg;
    logic          use_imm_reg;
    logic [1:0]    shift_reg;
    logic          wsel_reg;
    logic [W-1:0]  a_reg, b_reg, c_reg, result_reg;
    logic          z_reg, n_reg, v_reg;
    logic          resp_valid_reg, req_ready_reg;

    logic [W-1:0]  rf_a, rf_b, b_shift, alu_c;
    logic          alu_v, rf_we;

    assign rf_we = (state_reg == S_WB) && op_writes(op_reg);

    dp_regfile #(.W(W), .NREG(NREG)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rd_reg),
        .wdata   (result_reg),
        .raddr_a (rs1_reg),
        .raddr_b (rs2_reg),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    always_comb begin
        b_shift = rf_b;
        case (shift_reg)
            SH_LSL:  b_shift = {rf_b[W-2:0], 1'b0};
            SH_LSR:  b_shift = {1'b0, rf_b[W-1:1]};
            SH_ASR:  b_shift = {rf_b[W-1], rf_b[W-1:1]};
            default: b_shift = rf_b;
        endcase
    end

    // NOP (and disabled MUL) leaves C untouched so result repeats the last value.
    always_comb begin
        alu_c = c_reg;
        alu_v = 1'b0;
        case (op_reg)
            OP_ADD: begin
                alu_c = a_reg + b_reg;
                alu_v = (a_reg[W-1] == b_reg[W-1]) && (alu_c[W-1] != a_reg[W-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_c = a_reg - b_reg;
                alu_v = (a_reg[W-1] != b_reg[W-1]) && (alu_c[W-1] != a_reg[W-1]);
            end
            OP_AND:  alu_c = a_reg & b_reg;
            OP_MVN:  alu_c = ~b_reg;
            OP_MOV:  alu_c = b_reg;
            default: alu_c = c_reg;
        endcase
    end

`ifdef DP_MUL_EN
    localparam int CW = $clog2(W);
    logic [2*W-1:0] prod_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod_next;

    // Shift-add step: high half accumulates B when the multiplier LSB is set.
    assign mul_sum   = {1'b0, prod_reg[2*W-1:W]} + (prod_reg[0] ? {1'b0, b_reg} : {(W+1){1'b0}});
    assign prod_next = {mul_sum, prod_reg[W-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            op_reg         <= OP_NOP;
            rd_reg         <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            imm_reg        <= '0;
            use_imm_reg    <= 1'b0;
            shift_reg      <= SH_NONE;
            wsel_reg       <= WSEL_ALU;
            a_reg          <= '0;
            b_reg          <= '0;
            c_reg          <= '0;
            result_reg     <= '0;
            z_reg          <= 1'b0;
            n_reg          <= 1'b0;
            v_reg          <= 1'b0;
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
`ifdef DP_MUL_EN
            prod_reg       <= '0;
            cnt_reg        <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        op_reg        <= op;
                        rd_reg        <= rd;
                        rs1_reg       <= rs1;
                        rs2_reg       <= rs2;
                        imm_reg       <= imm;
                        use_imm_reg   <= use_imm;
                        shift_reg     <= shift;
                        wsel_reg      <= wsel;
                        req_ready_reg <= 1'b0;
                        state_reg     <= S_READ;
                    end
                end
                S_READ: begin
                    a_reg <= rf_a;
                    b_reg <= use_imm_reg ? imm_reg : b_shift;
`ifdef DP_MUL_EN
                    prod_reg <= {{W{1'b0}}, rf_a};
                    cnt_reg  <= '0;
                    state_reg <= (op_reg == OP_MUL) ? S_MUL : S_EXEC;
`else
                    state_reg <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    c_reg <= alu_c;
                    if (!op_is_nop(op_reg)) begin
                        z_reg <= (alu_c == '0);
                        n_reg <= alu_c[W-1];
                        v_reg <= alu_v;
                    end
                    result_reg     <= (wsel_reg == WSEL_MEM) ? mdata : alu_c;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= S_WB;
                end
`ifdef DP_MUL_EN
                S_MUL: begin
                    prod_reg <= prod_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(W-1)) begin
                        c_reg          <= prod_next[W-1:0];
                        z_reg          <= (prod_next[W-1:0] == '0);
                        n_reg          <= prod_next[W-1];
                        v_reg          <= |prod_next[2*W-1:W];
                        result_reg     <= (wsel_reg == WSEL_MEM) ? mdata : prod_next[W-1:0];
                        resp_valid_reg <= 1'b1;
                        state_reg      <= S_WB;
                    end
                end
`endif
                S_WB: begin
                    resp_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign result     = result_reg;
    assign z_out      = z_reg;
    assign n_out      = n_reg;
    assign v_out      = v_reg;

endmodule

// File: tb/tb_dp_core.sv
// Directed, table-driven bench for dp_core (W=16, NREG=8); MUL checks are
// selected with DP_MUL_EN to match the design build.
module tb_dp_core;
    import dp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic        use_imm;
    logic [1:0]  shift;
    logic        wsel;
    logic [15:0] mdata;
    logic        resp_valid;
    logic [15:0] result;
    logic        z_out, n_out, v_out;

    int total = 0;
    int bad   = 0;

    dp_core #(.W(16), .NREG(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .use_imm    (use_imm),
        .shift      (shift),
        .wsel       (wsel),
        .mdata      (mdata),
        .resp_valid (resp_valid),
        .result     (result),
        .z_out      (z_out),
        .n_out      (n_out),
        .v_out      (v_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic        use_imm;
        logic [1:0]  shift;
        logic        wsel;
        logic [15:0] mdata;
        logic        chk_res;
        logic [15:0] exp_res;
        logic [2:0]  exp_znv;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [2:0] op_i, input logic [2:0] rd_i,
                                input logic [2:0] rs1_i, input logic [2:0] rs2_i,
                                input logic [15:0] imm_i, input logic ui, input logic [1:0] sh,
                                input logic ws, input logic [15:0] md, input logic cr,
                                input logic [15:0] er, input logic [2:0] ez);
        vec_t v;
        v.op = op_i; v.rd = rd_i; v.rs1 = rs1_i; v.rs2 = rs2_i;
        v.imm = imm_i; v.use_imm = ui; v.shift = sh; v.wsel = ws; v.mdata = md;
        v.chk_res = cr; v.exp_res = er; v.exp_znv = ez;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op_i, input logic [2:0] rd_i, input logic [2:0] rs1_i,
                         input logic [2:0] rs2_i, input logic [15:0] imm_i, input logic ui,
                         input logic [1:0] sh, input logic ws, input logic [15:0] md,
                         output logic [15:0] res_o, output logic [2:0] znv_o, output int lat_o);
        int cnt;
        @(negedge clk);
        op = op_i; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; imm = imm_i;
        use_imm = ui; shift = sh; wsel = ws; mdata = md; req_valid = 1'b1;
        check("ready_before_accept", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cnt = 0;
        res_o = '0; znv_o = '0; lat_o = -1;
        while (cnt < 40) begin
            @(posedge clk);
            #1 cnt++;
            if (resp_valid) break;
        end
        if (resp_valid) begin
            lat_o = cnt + 1;
            res_o = result;
            znv_o = {z_out, n_out, v_out};
        end
        @(posedge clk);
        #1;
        check("resp_single_cycle", resp_valid, 0);
        check("ready_after_wb", req_ready, 1);
        $display("op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ui=%0d sh=%0d ws=%0d -> result=%h znv=%b lat=%0d",
                 op_i, rd_i, rs1_i, rs2_i, imm_i, ui, sh, ws, res_o, znv_o, lat_o);
    endtask

    task automatic read_reg(input logic [2:0] r, input logic [15:0] exp, input string name);
        logic [15:0] res;
        logic [2:0]  znv;
        int          lat;
        do_op(OP_MOV, r, 3'd0, r, 16'h0, 1'b0, SH_NONE, WSEL_ALU, 16'h0, res, znv, lat);
        check(name, res, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        logic [2:0]  znv;
        int          lat, acc, hi, pulses, resp_after_rst;
        logic        prev;

        vt[0]  = mk(OP_MOV, 1, 0, 0, 16'h0042, 1, SH_NONE, 0, 16'h0, 1, 16'h0042, 3'b000);
        vt[1]  = mk(OP_MOV, 1, 0, 0, 16'h7FFF, 1, SH_NONE, 0, 16'h0, 1, 16'h7FFF, 3'b000);
        vt[2]  = mk(OP_MOV, 2, 0, 0, 16'h0001, 1, SH_NONE, 0, 16'h0, 1, 16'h0001, 3'b000);
        vt[3]  = mk(OP_ADD, 3, 1, 2, 16'h0000, 0, SH_NONE, 0, 16'h0, 1, 16'h8000, 3'b011);
        vt[4]  = mk(OP_MOV, 1, 0, 0, 16'h0005, 1, SH_NONE, 0, 16'h0, 1, 16'h0005, 3'b000);
        vt[5]  = mk(OP_MOV, 2, 0, 0, 16'h0005, 1, SH_NONE, 0, 16'h0, 1, 16'h0005, 3'b000);
        vt[6]  = mk(OP_MOV, 4, 0, 0, 16'h00AA, 1, SH_NONE, 0, 16'h0, 1, 16'h00AA, 3'b000);
        vt[7]  = mk(OP_CMP, 4, 1, 2, 16'h0000, 0, SH_NONE, 0, 16'h0, 1, 16'h0000, 3'b100);
        vt[8]  = mk(OP_MOV, 4, 0, 4, 16'h0000, 0, SH_NONE, 0, 16'h0, 1, 16'h00AA, 3'b000);
        vt[9]  = mk(OP_MOV, 2, 0, 0, 16'h8001, 1, SH_NONE, 0, 16'h0, 1, 16'h8001, 3'b010);
        vt[10] = mk(OP_MOV, 5, 0, 2, 16'h0000, 0, SH_ASR,  0, 16'h0, 1, 16'hC000, 3'b010);
        vt[11] = mk(OP_MOV, 5, 0, 2, 16'h0000, 0, SH_LSR,  0, 16'h0, 1, 16'h4000, 3'b000);
        vt[12] = mk(OP_MOV, 5, 0, 2, 16'h0000, 0, SH_LSL,  0, 16'h0, 1, 16'h0002, 3'b000);
        vt[13] = mk(OP_SUB, 6, 1, 2, 16'h0000, 0, SH_NONE, 0, 16'h0, 1, 16'h8004, 3'b011);
        vt[14] = mk(OP_AND, 6, 2, 0, 16'h00FF, 1, SH_NONE, 0, 16'h0, 1, 16'h0001, 3'b000);
        vt[15] = mk(OP_MVN, 7, 0, 0, 16'hFFFF, 1, SH_NONE, 0, 16'h0, 1, 16'h0000, 3'b100);
        vt[16] = mk(OP_MOV, 7, 0, 0, 16'h0000, 1, SH_NONE, 1, 16'hBEEF, 1, 16'hBEEF, 3'b100);
        vt[17] = mk(OP_MOV, 7, 0, 7, 16'h0000, 0, SH_NONE, 0, 16'h0, 1, 16'hBEEF, 3'b010);
        vt[18] = mk(OP_ADD, 0, 2, 2, 16'h0000, 0, SH_NONE, 0, 16'h0, 1, 16'h0002, 3'b001);
        vt[19] = mk(OP_NOP, 5, 1, 1, 16'h0000, 0, SH_NONE, 0, 16'h0, 0, 16'h0000, 3'b001);
        vt[20] = mk(OP_MOV, 0, 0, 0, 16'h0000, 0, SH_NONE, 0, 16'h0, 1, 16'h0002, 3'b000);

        rst_n = 1'b0; req_valid = 1'b0; op = OP_NOP; rd = '0; rs1 = '0; rs2 = '0;
        imm = '0; use_imm = 1'b0; shift = SH_NONE; wsel = 1'b0; mdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_result", result, 16'h0);
        check("rst_flags", {z_out, n_out, v_out}, 3'b000);
        check("rst_resp", resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_op(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].use_imm,
                  vt[i].shift, vt[i].wsel, vt[i].mdata, res, znv, lat);
            check($sformatf("v%0d_latency", i), lat, 3);
            if (vt[i].chk_res) check($sformatf("v%0d_result", i), res, vt[i].exp_res);
            check($sformatf("v%0d_znv", i), znv, vt[i].exp_znv);
        end
        read_reg(3'd3, 16'h8000, "r3_after_add");
        read_reg(3'd1, 16'h0005, "r1_value");

`ifdef DP_MUL_EN
        do_op(OP_MOV, 1, 0, 0, 16'h0100, 1, SH_NONE, 0, 16'h0, res, znv, lat);
        do_op(OP_MOV, 2, 0, 0, 16'h0100, 1, SH_NONE, 0, 16'h0, res, znv, lat);
        do_op(OP_MUL, 3, 1, 2, 16'h0000, 0, SH_NONE, 0, 16'h0, res, znv, lat);
        check("mul_ovf_latency", lat, 18);
        check("mul_ovf_result", res, 16'h0000);
        check("mul_ovf_znv", znv, 3'b101);
        read_reg(3'd3, 16'h0000, "r3_after_mul");
        do_op(OP_MOV, 1, 0, 0, 16'h0003, 1, SH_NONE, 0, 16'h0, res, znv, lat);
        do_op(OP_MOV, 2, 0, 0, 16'h0005, 1, SH_NONE, 0, 16'h0, res, znv, lat);
        do_op(OP_MUL, 3, 1, 2, 16'h0000, 0, SH_NONE, 0, 16'h0, res, znv, lat);
        check("mul_small_latency", lat, 18);
        check("mul_small_result", res, 16'h000F);
        check("mul_small_znv", znv, 3'b000);
`else
        do_op(OP_CMP, 4, 2, 2, 16'h0000, 0, SH_NONE, 0, 16'h0, res, znv, lat);
        check("cmp_eq_znv", znv, 3'b100);
        do_op(OP_MUL, 3, 2, 2, 16'h0000, 0, SH_NONE, 0, 16'h0, res, znv, lat);
        check("op6_nop_latency", lat, 3);
        check("op6_nop_znv", znv, 3'b100);
        read_reg(3'd3, 16'h8000, "r3_after_op6");
`endif

        // req_valid held for 12 cycles: one acceptance per 4-cycle op.
        @(negedge clk);
        op = OP_MOV; rd = 3'd7; use_imm = 1'b1; imm = 16'h1111; shift = SH_NONE;
        wsel = 1'b0; req_valid = 1'b1;
        acc = 0; hi = 0; pulses = 0; prev = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (req_ready) acc++;
            if (resp_valid) begin
                hi++;
                if (!prev) pulses++;
            end
            prev = resp_valid;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (resp_valid) begin
                hi++;
                if (!prev) pulses++;
            end
            prev = resp_valid;
            @(negedge clk);
        end
        $display("hold12: accepts=%0d resp_cycles=%0d resp_pulses=%0d", acc, hi, pulses);
        check("hold_accepts", acc, 3);
        check("hold_resp_cycles", hi, 3);
        check("hold_resp_pulses", pulses, 3);

        // Reset pulsed while the op is in EXEC.
        @(negedge clk);
        op = OP_MOV; rd = 3'd6; use_imm = 1'b1; imm = 16'h1234; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", req_ready, 1);
        check("abort_resp", resp_valid, 0);
        check("abort_result", result, 16'h0);
        check("abort_flags", {z_out, n_out, v_out}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        resp_after_rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) resp_after_rst++;
        end
        $display("abort: resp_after_reset=%0d", resp_after_rst);
        check("abort_no_resp", resp_after_rst, 0);
        read_reg(3'd6, 16'h0000, "r6_after_abort");
        read_reg(3'd7, 16'h0000, "r7_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
